imem_fetch_unit: RTL and testbench



---
 rtl/imem_fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_imem_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a program-load port and a ready/valid burst fetch
// path; a credit-limited output queue absorbs consumer backpressure.
module imem_fetch_unit #(
  parameter int WORD_SIZE    = 19,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int READ_LATENCY = 1,
  parameter int LEN_W        = 4,
  parameter int Q_DEPTH      = READ_LATENCY + 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [LEN_W-1:0]     req_len,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_instr,
  output logic [ADDR_W-1:0]    rsp_addr,
  output logic                 rsp_err,
  output logic                 rsp_last,
  output logic                 busy
);

  localparam int QP = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int QC = $clog2(Q_DEPTH + 1);
  localparam int FW = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [QP-1:0]     Q_LAST    = QP'(Q_DEPTH - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic              err;
    logic [ADDR_W-1:0] addr;
  } meta_t;

  typedef struct packed {
    logic                 last;
    logic                 err;
    logic [ADDR_W-1:0]    addr;
    logic [WORD_SIZE-1:0] instr;
  } entry_t;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] data_q [READ_LATENCY];
  entry_t               q_mem [Q_DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  meta_t             meta_q [READ_LATENCY];
  meta_t             meta_d [READ_LATENCY];
  logic [QP-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [QC-1:0]     occ_q, occ_d;

  logic [FW-1:0] in_flight;
  logic          issue_fire, credit_ok, push, pop;
  entry_t        push_entry, head;

  // Contents are deliberately not reset so a loaded program survives a core reset.
  always_ff @(posedge CLK) begin
    if (load_en && ({1'b0, load_addr} < DEPTH_X)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (issue_fire) begin
      data_q[0] <= mem[ptr_q];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + FW'(meta_q[i].valid);
    end
  end

  // The word leaving the queue this cycle frees its slot, keeping full throughput.
  assign credit_ok = (int'(in_flight) + int'(occ_q) - int'(pop)) < Q_DEPTH;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    issue_fire = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !load_en;
        if (req_valid && !load_en) begin
          ptr_d   = req_addr;
          cnt_d   = req_len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_fire = !load_en && credit_ok;
        if (issue_fire) begin
          ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    meta_d[0].valid = issue_fire;
    meta_d[0].last  = (cnt_q == '0);
    meta_d[0].err   = ({1'b0, ptr_q} >= DEPTH_X);
    meta_d[0].addr  = ptr_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      meta_d[i] = meta_q[i-1];
    end
  end

  assign push             = meta_q[READ_LATENCY-1].valid;
  assign push_entry.last  = meta_q[READ_LATENCY-1].last;
  assign push_entry.err   = meta_q[READ_LATENCY-1].err;
  assign push_entry.addr  = meta_q[READ_LATENCY-1].addr;
  assign push_entry.instr = meta_q[READ_LATENCY-1].err ? '0 : data_q[READ_LATENCY-1];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      wr_d = (wr_q == Q_LAST) ? '0 : wr_q + QP'(1);
    end
    if (pop) begin
      rd_d = (rd_q == Q_LAST) ? '0 : rd_q + QP'(1);
    end
    occ_d = occ_q + QC'(push) - QC'(pop);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        meta_q[i] <= meta_d[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_mem[wr_q] <= push_entry;
    end
  end

  // Outputs are gated by rsp_valid so they read as zero whenever the queue is empty.
  assign head      = q_mem[rd_q];
  assign rsp_valid = (occ_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_instr = rsp_valid ? head.instr : '0;
  assign rsp_addr  = rsp_valid ? head.addr : '0;
  assign rsp_err   = rsp_valid && head.err;
  assign rsp_last  = rsp_valid && head.last;
  assign busy      = (state_q == ISSUE) || (in_flight != '0) || (occ_q != '0);

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: a scoreboard queue is filled when a
// burst is accepted and drained by a monitor as responses are consumed.
module tb_imem_fetch_unit;

  localparam int WS    = 19;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int RL    = 2;
  localparam int LW    = 4;

  typedef struct {
    logic [WS-1:0] instr;
    logic [AW-1:0] addr;
    logic          err;
    logic          last;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [WS-1:0] load_data;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [WS-1:0] rsp_instr;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;
  logic          rsp_last;
  logic          busy;

  exp_t          sb[$];
  logic [WS-1:0] model_mem [1024];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            first_valid_cyc = -1;
  int            last_pop_cyc = -1;
  int            t_acc;
  int            seen;
  logic          bp_mode = 1'b0;
  int            bp_idx = 0;
  logic [3:0]    bp_pat = 4'b1001;
  logic          prev_stall = 1'b0;
  logic [31:0]   snap;

  imem_fetch_unit #(
    .WORD_SIZE(WS), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(RL), .LEN_W(LW)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic loadWord(input logic [AW-1:0] a, input logic [WS-1:0] d);
    @(posedge CLK); #1;
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    model_mem[a] = d;
    @(posedge CLK); #1;
    load_en = 1'b0;
  endtask

  // Drives one request, waits for acceptance and queues the expected words.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [LW-1:0] len, output int t_accept);
    logic [AW-1:0] ad;
    exp_t          e;
    int            n;
    @(posedge CLK); #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = len;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) checkOutput("req_accept_timeout", 32'(req_ready), 32'(1));
    t_accept = cyc + 1;
    first_valid_cyc = -1;
    ad = a;
    for (int i = 0; i <= int'(len); i++) begin
      e.err   = (int'(ad) >= DEPTH);
      e.instr = e.err ? '0 : model_mem[ad];
      e.addr  = ad;
      e.last  = (i == int'(len));
      sb.push_back(e);
      ad = (int'(ad) == DEPTH - 1) ? '0 : ad + 10'd1;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("drain_done", 32'(sb.size() == 0 && !busy), 32'(1));
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (bp_mode) begin
        rsp_ready = bp_pat[bp_idx % 4];
        bp_idx++;
      end
    end
  end

  // Monitor: scoreboard compare on every handshake, plus hold checks while stalled.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      prev_stall = 1'b0;
    end else begin
      if (rsp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall)
        checkOutput("stall_hold", {rsp_valid, rsp_last, rsp_err, rsp_addr, rsp_instr}, snap);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_without_expectation", 32'(sb.size()), 32'(1));
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_instr", 32'(rsp_instr), 32'(e.instr));
          checkOutput("rsp_addr", 32'(rsp_addr), 32'(e.addr));
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
          checkOutput("rsp_last", 32'(rsp_last), 32'(e.last));
        end
        last_pop_cyc = cyc;
      end
      prev_stall = rsp_valid && !rsp_ready;
      snap = {rsp_valid, rsp_last, rsp_err, rsp_addr, rsp_instr};
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge CLK);
    $display("[TB] reset values");
    checkOutput("rst_req_ready", 32'(req_ready), 32'(1));
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_rsp_instr", 32'(rsp_instr), 32'(0));
    checkOutput("rst_rsp_addr", 32'(rsp_addr), 32'(0));
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'(0));
    checkOutput("rst_rsp_last", 32'(rsp_last), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;

    $display("[TB] basic 4-word burst");
    for (int i = 0; i < 6; i++) loadWord(AW'(i), WS'(i + 1));
    applyStimulus(10'd0, 4'd3, t_acc);
    @(negedge CLK);
    checkOutput("burst_req_ready", 32'(req_ready), 32'(0));
    checkOutput("burst_busy", 32'(busy), 32'(1));
    waitDrain(40);
    checkOutput("first_latency", 32'(first_valid_cyc - t_acc), 32'(1 + RL));
    checkOutput("burst_span", 32'(last_pop_cyc - first_valid_cyc), 32'(3));

    $display("[TB] toggling backpressure");
    bp_idx = 0;
    bp_mode = 1'b1;
    applyStimulus(10'd0, 4'd3, t_acc);
    waitDrain(80);
    bp_mode = 1'b0;
    rsp_ready = 1'b1;

    $display("[TB] credit exhaustion with consumer stalled");
    rsp_ready = 1'b0;
    applyStimulus(10'd0, 4'd5, t_acc);
    repeat (10) @(negedge CLK);
    checkOutput("stalled_valid", 32'(rsp_valid), 32'(1));
    checkOutput("stalled_addr", 32'(rsp_addr), 32'(0));
    checkOutput("stalled_instr", 32'(rsp_instr), 32'(1));
    checkOutput("stalled_req_ready", 32'(req_ready), 32'(0));
    checkOutput("stalled_busy", 32'(busy), 32'(1));
    rsp_ready = 1'b1;
    waitDrain(60);

    $display("[TB] address wrap and out-of-range");
    loadWord(10'd999, 19'h7FFFF);
    loadWord(10'd0, 19'h12345);
    applyStimulus(10'd999, 4'd1, t_acc);
    waitDrain(40);
    applyStimulus(10'd1000, 4'd0, t_acc);
    waitDrain(40);
    applyStimulus(10'd1022, 4'd2, t_acc);
    waitDrain(40);

    $display("[TB] load during burst");
    applyStimulus(10'd0, 4'd3, t_acc);
    @(posedge CLK); #1;
    load_en = 1'b1; load_addr = 10'd10; load_data = 19'h0ABCD;
    model_mem[10] = 19'h0ABCD;
    @(negedge CLK);
    checkOutput("load_req_ready", 32'(req_ready), 32'(0));
    @(posedge CLK); #1;
    load_en = 1'b0;
    waitDrain(40);
    checkOutput("load_first_latency", 32'(first_valid_cyc - t_acc), 32'(1 + RL));
    checkOutput("load_burst_span", 32'(last_pop_cyc - first_valid_cyc), 32'(4));
    applyStimulus(10'd10, 4'd0, t_acc);
    waitDrain(40);

    $display("[TB] reset mid-burst");
    rsp_ready = 1'b0;
    applyStimulus(10'd0, 4'd3, t_acc);
    repeat (6) @(negedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    checkOutput("midrst_req_ready", 32'(req_ready), 32'(1));
    checkOutput("midrst_rsp_instr", 32'(rsp_instr), 32'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (rsp_valid) seen++;
    end
    checkOutput("no_rsp_after_reset", 32'(seen), 32'(0));
    applyStimulus(10'd0, 4'd3, t_acc);
    waitDrain(40);
    applyStimulus(10'd10, 4'd0, t_acc);
    waitDrain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
